// File: rtl/player1_encoder_pkg.sv
// Shared definitions for the player 1 code recorder: state encoding and default sizes.
package spy_pkg;

    localparam int WIDTH_DEFAULT = 18;
    localparam int LEN_W_DEFAULT = $clog2(WIDTH_DEFAULT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd1,
        LOCKED = 2'd2,
        REPLAY = 2'd3
    } state_t;

endpackage

// File: rtl/player1_encoder_if.sv
// player1_value bus: the recorded code, its length and the lock flag seen by player 2.
interface player1_encoder_if
    import spy_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int LEN_W = LEN_W_DEFAULT
) ();

    logic [WIDTH-1:0] player1_value;
    logic [LEN_W-1:0] value_len;
    logic             value_valid;

    modport master (output player1_value, output value_len, output value_valid);
    modport slave  (input  player1_value, input  value_len, input  value_valid);

endinterface

// File: rtl/player1_encoder_key_sync.sv
// Two-flop synchroniser for an active-low key plus a one-cycle press (falling edge) pulse.
module key_sync
    import spy_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic fall
);

    logic meta_reg;
    logic sync_reg;
    logic prev_reg;

    // Reset to the released level so a held key does not look like a fresh press.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_reg <= 1'b1;
            sync_reg <= 1'b1;
            prev_reg <= 1'b1;
        end else begin
            meta_reg <= pin;
            sync_reg <= meta_reg;
            prev_reg <= sync_reg;
        end
    end

    assign level = sync_reg;
    assign fall  = prev_reg & ~sync_reg;

endmodule

// File: rtl/player1_encoder.sv
// Records player 1's code one bit per game tick, locks it for player 2 and can replay it serially.
module player1_encoder
    import spy_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int LEN_W = LEN_W_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tick,
    input  logic             enable,
    input  logic             value_input,
    input  logic             finish_input,
    input  logic             replay_req,
    player1_encoder_if.master p1_bus,
    output logic             replay_bit,
    output logic             replay_active,
    output logic [WIDTH-1:0] q
);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic [LEN_W-1:0] len_reg, len_next;
    logic [LEN_W-1:0] index_reg, index_next;
    logic             valid_reg, valid_next;
    logic             rbit_reg, rbit_next;
    logic             enable_prev_reg;

    logic value_level;
    logic finish_fall;
    logic unused_value_fall;
    logic unused_finish_level;
    logic enable_rise;
    logic sample;

    key_sync u_value_sync (
        .clock (clock),
        .reset (reset),
        .pin   (value_input),
        .level (value_level),
        .fall  (unused_value_fall)
    );

    key_sync u_finish_sync (
        .clock (clock),
        .reset (reset),
        .pin   (finish_input),
        .level (unused_finish_level),
        .fall  (finish_fall)
    );

    assign enable_rise = enable & ~enable_prev_reg;
    assign sample      = tick && (len_reg != LEN_W'(WIDTH));

    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        len_next   = len_reg;
        index_next = index_reg;
        valid_next = valid_reg;
        rbit_next  = rbit_reg;
        case (state_reg)
            IDLE: begin
                if (enable_rise) begin
                    state_next = RECORD;
                    shift_next = '0;
                    len_next   = '0;
                end
            end
            RECORD: begin
                if (!enable) begin
                    state_next = IDLE;
                    shift_next = '0;
                    len_next   = '0;
                end else begin
                    if (sample) begin
                        shift_next = {shift_reg[WIDTH-2:0], ~value_level};
                        len_next   = len_reg + LEN_W'(1);
                    end
                    // A bit taken on this same tick counts toward a non-empty code.
                    if (finish_fall && ((len_reg != '0) || sample)) begin
                        state_next = LOCKED;
                        valid_next = 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (enable_rise) begin
                    state_next = RECORD;
                    shift_next = '0;
                    len_next   = '0;
                    valid_next = 1'b0;
                end else if (replay_req) begin
                    state_next = REPLAY;
                    index_next = len_reg - LEN_W'(1);
                    rbit_next  = shift_reg[len_reg - LEN_W'(1)];
                end
            end
            REPLAY: begin
                if (enable_rise) begin
                    state_next = RECORD;
                    shift_next = '0;
                    len_next   = '0;
                    valid_next = 1'b0;
                    index_next = '0;
                    rbit_next  = 1'b0;
                end else if (tick) begin
                    if (index_reg == '0) begin
                        state_next = LOCKED;
                        rbit_next  = 1'b0;
                    end else begin
                        index_next = index_reg - LEN_W'(1);
                        rbit_next  = shift_reg[index_reg - LEN_W'(1)];
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // enable history resets high so a level held through reset must re-rise to start a round.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            shift_reg       <= '0;
            len_reg         <= '0;
            index_reg       <= '0;
            valid_reg       <= 1'b0;
            rbit_reg        <= 1'b0;
            enable_prev_reg <= 1'b1;
        end else begin
            state_reg       <= state_next;
            shift_reg       <= shift_next;
            len_reg         <= len_next;
            index_reg       <= index_next;
            valid_reg       <= valid_next;
            rbit_reg        <= rbit_next;
            enable_prev_reg <= enable;
        end
    end

    assign p1_bus.player1_value = shift_reg;
    assign p1_bus.value_len     = len_reg;
    assign p1_bus.value_valid   = valid_reg;
    assign q                    = shift_reg;
    assign replay_bit           = rbit_reg;
    assign replay_active        = (state_reg == REPLAY);

endmodule

// File: tb/tb_player1_encoder.sv
// Bench for player1_encoder: scripted vector table, hand sequences and random traffic vs. a queue model.
module tb_player1_encoder;
    import spy_pkg::*;

    localparam int W  = 18;
    localparam int LW = 5;

    logic         clock = 1'b0;
    logic         reset;
    logic         tick, enable, value_input, finish_input, replay_req;
    logic         replay_bit, replay_active;
    logic [W-1:0] q;

    player1_encoder_if #(.WIDTH(W), .LEN_W(LW)) bus ();

    player1_encoder #(.WIDTH(W), .LEN_W(LW)) dut (
        .clock         (clock),
        .reset         (reset),
        .tick          (tick),
        .enable        (enable),
        .value_input   (value_input),
        .finish_input  (finish_input),
        .replay_req    (replay_req),
        .p1_bus        (bus),
        .replay_bit    (replay_bit),
        .replay_active (replay_active),
        .q             (q)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Behavioural model: the code is a queue of bits, first recorded bit first.
    localparam int M_IDLE = 0, M_REC = 1, M_LOCK = 2, M_PLAY = 3;
    bit code[$];
    int phase;
    int pos;
    bit en_prev;
    bit vh1, vh2, fh1, fh2, fh3;
    int lock_count;

    function automatic void model_reset();
        code.delete();
        phase   = M_IDLE;
        pos     = 0;
        en_prev = 1'b1;
        vh1 = 1'b1; vh2 = 1'b1;
        fh1 = 1'b1; fh2 = 1'b1; fh3 = 1'b1;
    endfunction

    function automatic void model_step(bit en, bit tk, bit v, bit f, bit rr);
        bit rise;
        bit vbit;
        bit press;
        rise  = en && !en_prev;
        vbit  = !vh2;
        press = fh3 && !fh2;
        case (phase)
            M_IDLE: if (rise) begin phase = M_REC; code.delete(); end
            M_REC: begin
                if (!en) begin
                    phase = M_IDLE;
                    code.delete();
                end else begin
                    if (tk && code.size() < W) code.push_back(vbit);
                    if (press && code.size() > 0) begin
                        phase = M_LOCK;
                        lock_count++;
                        $display("lock #%0d: %0d bits", lock_count, code.size());
                    end
                end
            end
            M_LOCK: begin
                if (rise) begin phase = M_REC; code.delete(); end
                else if (rr) begin phase = M_PLAY; pos = 0; end
            end
            default: begin
                if (rise) begin phase = M_REC; code.delete(); end
                else if (tk) begin
                    if (pos == code.size() - 1) phase = M_LOCK;
                    else pos++;
                end
            end
        endcase
        vh2 = vh1; vh1 = v;
        fh3 = fh2; fh2 = fh1; fh1 = f;
        en_prev = en;
    endfunction

    function automatic logic [W-1:0] m_value();
        logic [W-1:0] r;
        r = '0;
        foreach (code[i]) r = {r[W-2:0], code[i]};
        return r;
    endfunction

    function automatic bit m_rbit();
        if (phase == M_PLAY) return code[pos];
        return 1'b0;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("model value",  32'(bus.player1_value), 32'(m_value()));
        chk("model q",      32'(q),                 32'(m_value()));
        chk("model len",    32'(bus.value_len),     32'(code.size()));
        chk("model valid",  32'(bus.value_valid),   32'(phase == M_LOCK || phase == M_PLAY));
        chk("model active", 32'(replay_active),     32'(phase == M_PLAY));
        chk("model rbit",   32'(replay_bit),        32'(m_rbit()));
    endtask

    task automatic cycle(bit en, bit tk, bit v, bit f, bit rr);
        enable = en; tick = tk; value_input = v; finish_input = f; replay_req = rr;
        @(posedge clock);
        model_step(en, tk, v, f, rr);
        #1;
        compare_model();
    endtask

    task automatic expect_out(string tag, int val, int len, bit vld);
        chk({tag, " value"}, 32'(bus.player1_value), 32'(val));
        chk({tag, " len"},   32'(bus.value_len),     32'(len));
        chk({tag, " valid"}, 32'(bus.value_valid),   32'(vld));
        $display("%s: value=%05h len=%0d valid=%0b", tag, bus.player1_value, bus.value_len, bus.value_valid);
    endtask

    // Pin held for three cycles so the tick sees the synchronised level.
    task automatic press_bit(bit b);
        cycle(1, 0, !b, 1, 0);
        cycle(1, 0, !b, 1, 0);
        cycle(1, 1, !b, 1, 0);
    endtask

    task automatic do_finish();
        cycle(1, 0, 1, 0, 0);
        cycle(1, 0, 1, 0, 0);
        cycle(1, 0, 1, 0, 0);
        cycle(1, 0, 1, 1, 0);
    endtask

    task automatic rise_enable();
        cycle(0, 0, 1, 1, 0);
        cycle(1, 0, 1, 1, 0);
    endtask

    task automatic async_reset();
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        chk("async value",  32'(bus.player1_value), 32'd0);
        chk("async q",      32'(q),                 32'd0);
        chk("async len",    32'(bus.value_len),     32'd0);
        chk("async valid",  32'(bus.value_valid),   32'd0);
        chk("async active", 32'(replay_active),     32'd0);
        $display("async reset mid-cycle: value=%05h len=%0d", bus.player1_value, bus.value_len);
        @(posedge clock);
        @(posedge clock);
        #2;
        reset = 1'b0;
    endtask

    typedef struct {
        bit           en, tk, v, f, rr, chk;
        logic [W-1:0] val;
        logic [LW-1:0] len;
        bit           vld, act, rb;
    } vec_t;

    function automatic vec_t mk(bit en, bit tk, bit v, bit f, bit rr, bit c,
                                int val, int len, bit vld, bit act, bit rb);
        vec_t r;
        r.en = en; r.tk = tk; r.v = v; r.f = f; r.rr = rr; r.chk = c;
        r.val = W'(val); r.len = LW'(len); r.vld = vld; r.act = act; r.rb = rb;
        return r;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        vec_t tbl[23];
        bit fpin;
        // en tk v f rr chk | value len valid active rbit  (records 1,0,1 then replays it)
        tbl[0]  = mk(0,0,1,1,0, 1, 0,0,0,0,0);
        tbl[1]  = mk(1,0,1,1,0, 1, 0,0,0,0,0);
        tbl[2]  = mk(1,0,0,1,0, 0, 0,0,0,0,0);
        tbl[3]  = mk(1,0,0,1,0, 0, 0,0,0,0,0);
        tbl[4]  = mk(1,1,0,1,0, 1, 1,1,0,0,0);
        tbl[5]  = mk(1,0,1,1,0, 0, 0,0,0,0,0);
        tbl[6]  = mk(1,0,1,1,0, 0, 0,0,0,0,0);
        tbl[7]  = mk(1,1,1,1,0, 1, 2,2,0,0,0);
        tbl[8]  = mk(1,0,0,1,0, 0, 0,0,0,0,0);
        tbl[9]  = mk(1,0,0,1,0, 0, 0,0,0,0,0);
        tbl[10] = mk(1,1,0,1,0, 1, 5,3,0,0,0);
        tbl[11] = mk(1,0,1,0,0, 1, 5,3,0,0,0);
        tbl[12] = mk(1,0,1,0,0, 1, 5,3,0,0,0);
        tbl[13] = mk(1,0,1,0,0, 1, 5,3,1,0,0);
        tbl[14] = mk(1,0,1,1,0, 1, 5,3,1,0,0);
        tbl[15] = mk(1,0,1,1,1, 1, 5,3,1,1,1);
        tbl[16] = mk(1,0,1,1,0, 1, 5,3,1,1,1);
        tbl[17] = mk(1,1,1,1,0, 1, 5,3,1,1,0);
        tbl[18] = mk(1,1,1,1,0, 1, 5,3,1,1,1);
        tbl[19] = mk(1,0,1,1,1, 1, 5,3,1,1,1);
        tbl[20] = mk(1,1,1,1,0, 1, 5,3,1,0,0);
        tbl[21] = mk(0,0,1,1,0, 1, 5,3,1,0,0);
        tbl[22] = mk(1,0,1,1,0, 1, 0,0,0,0,0);

        lock_count = 0;
        reset = 1'b1;
        enable = 1'b0; tick = 1'b0; value_input = 1'b1; finish_input = 1'b1; replay_req = 1'b0;
        model_reset();
        @(posedge clock);
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        expect_out("reset", 0, 0, 0);
        chk("reset active", 32'(replay_active), 32'd0);
        chk("reset rbit",   32'(replay_bit),    32'd0);
        chk("reset q",      32'(q),             32'd0);

        for (int i = 0; i < 23; i++) begin
            cycle(tbl[i].en, tbl[i].tk, tbl[i].v, tbl[i].f, tbl[i].rr);
            if (tbl[i].chk) begin
                chk($sformatf("row%0d value", i),  32'(bus.player1_value), 32'(tbl[i].val));
                chk($sformatf("row%0d len", i),    32'(bus.value_len),     32'(tbl[i].len));
                chk($sformatf("row%0d valid", i),  32'(bus.value_valid),   32'(tbl[i].vld));
                chk($sformatf("row%0d active", i), 32'(replay_active),     32'(tbl[i].act));
                chk($sformatf("row%0d rbit", i),   32'(replay_bit),        32'(tbl[i].rb));
                $display("row %0d: value=%05h len=%0d valid=%0b active=%0b rbit=%0b",
                         i, bus.player1_value, bus.value_len, bus.value_valid, replay_active, replay_bit);
            end
        end

        // Finish with nothing recorded is ignored; recording continues afterwards.
        do_finish();
        expect_out("empty finish", 0, 0, 0);
        press_bit(1);
        expect_out("after empty finish tick", 1, 1, 0);
        do_finish();
        expect_out("one-bit lock", 1, 1, 1);

        // Saturation at WIDTH bits.
        rise_enable();
        for (int i = 1; i <= 20; i++) begin
            press_bit(1);
            if (i < W) expect_out($sformatf("fill tick %0d", i), (1 << i) - 1, i, 0);
            else       expect_out($sformatf("fill tick %0d", i), 32'h3FFFF, W, 0);
        end
        do_finish();
        expect_out("full lock", 32'h3FFFF, W, 1);

        // Asynchronous reset mid-record; enable held high must re-rise.
        rise_enable();
        press_bit(1);
        press_bit(0);
        expect_out("before async reset", 2, 2, 0);
        async_reset();
        press_bit(1);
        expect_out("enable held after reset", 0, 0, 0);
        do_finish();
        expect_out("finish after reset", 0, 0, 0);
        rise_enable();
        press_bit(1);
        expect_out("re-armed", 1, 1, 0);

        // Tick and finish press on the same edge.
        press_bit(0);
        expect_out("len two", 2, 2, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        expect_out("tick+finish", 5, 3, 1);
        cycle(1, 0, 1, 1, 0);
        expect_out("tick+finish hold", 5, 3, 1);

        // Enable dropped while recording.
        rise_enable();
        press_bit(1);
        press_bit(1);
        expect_out("before drop", 3, 2, 0);
        cycle(0, 0, 1, 1, 0);
        expect_out("enable drop", 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 1, 0, 1, 0);
        expect_out("idle ignores tick", 0, 0, 0);

        // Random traffic against the model.
        rise_enable();
        fpin = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            bit en, tk, v, rr;
            en = ($urandom_range(0, 99) < 97);
            tk = ($urandom_range(0, 3) == 0);
            v  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 11) == 0) fpin = !fpin;
            rr = ($urandom_range(0, 19) == 0);
            cycle(en, tk, v, fpin, rr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
